// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, register index and the write-port arbiter state.
package cpu_types_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [XLEN-1:0] word_t;
    typedef logic [4:0]      regbits_t;

    // A_PRI: pipeline writeback wins; B_FORCE: starved long-latency unit is served.
    typedef enum logic [0:0] {
        A_PRI   = 1'b0,
        B_FORCE = 1'b1
    } rfsched_state_t;

endpackage

// File: rtl/rf_write_scheduler_scoreboard.sv
// Busy scoreboard: one bit per register with an outstanding B-unit result.
module rf_scoreboard
    import cpu_types_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  regbits_t            set_sel,
    input  logic                clr_en,
    input  regbits_t            clr_sel,
    input  regbits_t            chk_sel1,
    input  regbits_t            chk_sel2,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_mask
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Per-register next value: a new issue overrides a same-edge writeback; r0 is never busy.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
            if (gi == 0) begin : g_r0
                always_comb busy_d[gi] = 1'b0;
            end else begin : g_rn
                logic set_hit;
                logic clr_hit;
                assign set_hit = set_en && (set_sel == regbits_t'(gi));
                assign clr_hit = clr_en && (clr_sel == regbits_t'(gi));
                always_comb busy_d[gi] = set_hit || (busy_q[gi] && !clr_hit);
            end
        end
    endgenerate

    // Scoreboard state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    // Hazard lookup uses registered state only; same-edge clears are not forwarded.
    always_comb stall = busy_q[chk_sel1] || busy_q[chk_sel2];

    assign busy_mask = busy_q;

endmodule

// File: rtl/rf_write_scheduler.sv
// Register-file write-port scheduler: A-priority arbitration with a starvation guard
// for the long-latency B unit, registered write outputs and a RAW busy scoreboard.
module rf_write_scheduler
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                a_valid,
    input  regbits_t            a_wsel,
    input  word_t               a_wdat,
    output logic                a_ready,
    input  logic                b_valid,
    input  regbits_t            b_wsel,
    input  word_t               b_wdat,
    output logic                b_ready,
    input  logic                issue_valid,
    input  regbits_t            issue_wsel,
    input  regbits_t            chk_sel1,
    input  regbits_t            chk_sel2,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                WEN,
    output regbits_t            wsel,
    output word_t               wdat
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    rfsched_state_t state_q, state_d;
    logic [3:0]     wait_cnt_q, wait_cnt_d;
    logic           wen_q, wen_d;
    regbits_t       wsel_q, wsel_d;
    word_t          wdat_q, wdat_d;

    logic a_xfer;
    logic b_xfer;

    assign a_xfer = a_valid && a_ready;
    assign b_xfer = b_valid && b_ready;

    // Arbiter state, starvation counter and write-port output register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= A_PRI;
            wait_cnt_q <= '0;
            wen_q      <= 1'b0;
            wsel_q     <= '0;
            wdat_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            wen_q      <= wen_d;
            wsel_q     <= wsel_d;
            wdat_q     <= wdat_d;
        end
    end

    // Count consecutive refusals of a waiting B request, saturating at the limit.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!b_valid || b_xfer) begin
            wait_cnt_d = '0;
        end else if (!b_ready) begin
            wait_cnt_d = (wait_cnt_q >= STARVE_LIM) ? STARVE_LIM : wait_cnt_q + 4'd1;
        end
    end

    // Next state: force B once it has waited the limit; release when B is served or gone.
    always_comb begin
        state_d = state_q;
        case (state_q)
            A_PRI:   if (wait_cnt_d == STARVE_LIM) state_d = B_FORCE;
            B_FORCE: if (b_xfer || !b_valid)       state_d = A_PRI;
            default: state_d = A_PRI;
        endcase
    end

    // Ready outputs follow the state combinationally.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        case (state_q)
            A_PRI: begin
                a_ready = 1'b1;
                b_ready = !a_valid;
            end
            B_FORCE: begin
                a_ready = 1'b0;
                b_ready = 1'b1;
            end
            default: ;
        endcase
    end

    // Load the winner's payload; a write to r0 is accepted but never enabled.
    always_comb begin
        wen_d  = 1'b0;
        wsel_d = wsel_q;
        wdat_d = wdat_q;
        if (a_xfer) begin
            wen_d  = (a_wsel != '0);
            wsel_d = a_wsel;
            wdat_d = a_wdat;
        end else if (b_xfer) begin
            wen_d  = (b_wsel != '0);
            wsel_d = b_wsel;
            wdat_d = b_wdat;
        end
    end

    assign WEN  = wen_q;
    assign wsel = wsel_q;
    assign wdat = wdat_q;

    rf_scoreboard u_scoreboard (
        .clk       (CLK),
        .rst       (RST),
        .set_en    (issue_valid),
        .set_sel   (issue_wsel),
        .clr_en    (b_xfer),
        .clr_sel   (b_wsel),
        .chk_sel1  (chk_sel1),
        .chk_sel2  (chk_sel2),
        .stall     (stall),
        .busy_mask (busy_mask)
    );

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler: stimulus pushes expected register-file
// writes into a queue, a negedge monitor pops and compares whenever WEN is high.
module tb_rf_write_scheduler;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        a_valid = 0, b_valid = 0, issue_valid = 0;
    logic [4:0]  a_wsel = 0, b_wsel = 0, issue_wsel = 0, chk_sel1 = 0, chk_sel2 = 0;
    logic [31:0] a_wdat = 0, b_wdat = 0;
    logic        a_ready, b_ready, stall, WEN;
    logic [31:0] busy_mask;
    logic [4:0]  wsel;
    logic [31:0] wdat;

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] dat;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    rf_write_scheduler #(.STARVE_MAX(4)) dut (
        .CLK(CLK), .RST(RST),
        .a_valid(a_valid), .a_wsel(a_wsel), .a_wdat(a_wdat), .a_ready(a_ready),
        .b_valid(b_valid), .b_wsel(b_wsel), .b_wdat(b_wdat), .b_ready(b_ready),
        .issue_valid(issue_valid), .issue_wsel(issue_wsel),
        .chk_sel1(chk_sel1), .chk_sel2(chk_sel2),
        .stall(stall), .busy_mask(busy_mask),
        .WEN(WEN), .wsel(wsel), .wdat(wdat)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every enabled write must match the oldest expected write.
    always @(negedge CLK) begin
        if (!RST && WEN) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write: unexpected WEN wsel=%0d wdat=0x%08h", wsel, wdat);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (wsel !== e.sel || wdat !== e.dat) begin
                    errors++;
                    $display("FAIL write: got r%0d=0x%08h expected r%0d=0x%08h",
                             wsel, wdat, e.sel, e.dat);
                end else begin
                    $display("ok   write: r%0d=0x%08h", wsel, wdat);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #12;
        chk("reset_wen", 32'(WEN), 0);
        chk("reset_busy", busy_mask, 0);
        chk("reset_a_ready", 32'(a_ready), 1);
        chk("reset_b_ready_idle", 32'(b_ready), 1);
        RST = 1'b0;
        step();

        // A-only write
        a_valid = 1; a_wsel = 5; a_wdat = 32'hDEADBEEF;
        #1;
        chk("a_only_a_ready", 32'(a_ready), 1);
        chk("a_only_b_ready", 32'(b_ready), 0);
        exp_q.push_back('{5'd5, 32'hDEADBEEF});
        step();
        a_valid = 0;
        chk("a_only_wen", 32'(WEN), 1);

        // Starvation: both valid continuously
        step();
        b_valid = 1; b_wsel = 2; b_wdat = 32'h0000_0B0B;
        a_valid = 1; a_wsel = 1;
        for (int k = 1; k <= 4; k++) begin
            a_wdat = 32'hA000_0000 + k;
            #1;
            chk($sformatf("starve_refuse%0d_b_ready", k), 32'(b_ready), 0);
            exp_q.push_back('{5'd1, a_wdat});
            step();
        end
        a_wdat = 32'hA000_0005;
        #1;
        chk("starve_force_a_ready", 32'(a_ready), 0);
        chk("starve_force_b_ready", 32'(b_ready), 1);
        exp_q.push_back('{5'd2, 32'h0000_0B0B});
        step();
        b_valid = 0;
        #1;
        chk("starve_after_a_ready", 32'(a_ready), 1);
        exp_q.push_back('{5'd1, 32'hA000_0005});
        step();
        a_valid = 0;

        // wait_cnt clears when b_valid drops: 3 refusals, gap, then 4 more needed
        a_valid = 1; a_wsel = 4; b_wsel = 3; b_wdat = 32'h0000_0333;
        b_valid = 1;
        for (int k = 1; k <= 8; k++) begin
            a_wdat = 32'hC000_0000 + k;
            b_valid = (k != 4);
            #1;
            if (k != 4) chk($sformatf("clr_cnt%0d_b_ready", k), 32'(b_ready), 0);
            exp_q.push_back('{5'd4, a_wdat});
            step();
        end
        #1;
        chk("clr_cnt_force_b_ready", 32'(b_ready), 1);
        exp_q.push_back('{5'd3, 32'h0000_0333});
        step();
        a_valid = 0; b_valid = 0;

        // A write to r0: accepted, never enabled
        a_valid = 1; a_wsel = 0; a_wdat = 32'h1234_5678;
        #1;
        chk("r0_a_ready", 32'(a_ready), 1);
        step();
        a_valid = 0;
        chk("r0_wen", 32'(WEN), 0);

        // Scoreboard set, stall, then B writeback clears
        issue_valid = 1; issue_wsel = 7;
        step();
        issue_valid = 0;
        chk("sb_set_busy", busy_mask, 32'h0000_0080);
        chk_sel2 = 7;
        #1;
        chk("sb_stall_sel2", 32'(stall), 1);
        b_valid = 1; b_wsel = 7; b_wdat = 32'h0000_0077;
        #1;
        chk("sb_b_ready", 32'(b_ready), 1);
        chk("sb_no_forward_stall", 32'(stall), 1);
        exp_q.push_back('{5'd7, 32'h0000_0077});
        step();
        b_valid = 0;
        chk("sb_clear_busy", busy_mask, 0);
        chk("sb_clear_stall", 32'(stall), 0);
        chk_sel2 = 0;

        // Same-edge set and clear: set wins
        issue_valid = 1; issue_wsel = 9;
        b_valid = 1; b_wsel = 9; b_wdat = 32'h0000_0999;
        exp_q.push_back('{5'd9, 32'h0000_0999});
        step();
        issue_valid = 0; b_valid = 0;
        chk("same_edge_busy", busy_mask, 32'h0000_0200);
        chk_sel1 = 9;
        #1;
        chk("same_edge_stall_sel1", 32'(stall), 1);
        chk_sel1 = 0;
        b_valid = 1; b_wsel = 9; b_wdat = 32'h0000_0990;
        exp_q.push_back('{5'd9, 32'h0000_0990});
        step();
        b_valid = 0;
        chk("same_edge_clear", busy_mask, 0);

        // r0 is never busy
        issue_valid = 1; issue_wsel = 0;
        step();
        issue_valid = 0;
        chk("r0_never_busy", busy_mask, 0);

        // Reset in B_FORCE with a pending write and r7 busy
        issue_valid = 1; issue_wsel = 7;
        step();
        issue_valid = 0;
        a_valid = 1; a_wsel = 6; b_valid = 1; b_wsel = 3; b_wdat = 32'h0000_0303;
        for (int k = 1; k <= 4; k++) begin
            a_wdat = 32'hE000_0000 + k;
            exp_q.push_back('{5'd6, a_wdat});
            step();
        end
        chk("rst_pre_wen", 32'(WEN), 1);
        chk("rst_pre_busy", busy_mask, 32'h0000_0080);
        chk("rst_pre_a_ready", 32'(a_ready), 0);
        RST = 1;
        #1;
        exp_q.delete();
        chk("rst_wen", 32'(WEN), 0);
        chk("rst_busy", busy_mask, 0);
        chk("rst_a_ready", 32'(a_ready), 1);
        a_valid = 0; b_valid = 0;
        step();
        RST = 0;
        step();
        step();

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
